// File: rtl/fft_twiddle_cmul4.sv
// fft_twiddle_cmul4: four-lane complex multiply of butterfly outputs by ROM twiddles.
// Numbers use the 9-bit small-float format: sign[8], exp[7:3] with bias 16, mant[2:0]
// with a hidden 1. An exponent of 0 means zero.
// Three pipeline stages:
//   S1 forms the four real products.
//   S2 aligns each pair of products.
//   S3 adds each pair, normalises it and registers the result.
// A beat counter flags the last beat of each 8-beat frame.
// Optional macro FFT_CMUL_TRIVIAL_BYPASS_EN: a lane whose twiddle is exactly 1+0j passes
// its data through bit-exact, with the same 3-cycle latency.
module fft_twiddle_cmul4 #(
  parameter int NB    = 9,
  parameter int LANES = 4,
  parameter int BEATS = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                DIN_VALID,
  input  logic [NB*LANES-1:0] DIN_RE,
  input  logic [NB*LANES-1:0] DIN_IM,
  input  logic [NB*LANES-1:0] W_RE,
  input  logic [NB*LANES-1:0] W_IM,
  output logic                DOUT_VALID,
  output logic [NB*LANES-1:0] DOUT_RE,
  output logic [NB*LANES-1:0] DOUT_IM,
  output logic                FRAME_DONE
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Aligned add operands handed from S2 to S3. A is the larger-magnitude operand.
  typedef struct packed {
    logic       sign;   // sign of A, which is also the sign of the result
    logic [4:0] exp;    // exponent of A
    logic [6:0] sig_a;  // hidden 1, mantissa, and 3 guard bits
    logic [6:0] sig_b;  // B significand shifted to A's exponent
    logic       sub;    // the operand signs differ
  } aln_t;

  // Apply the underflow and saturation rules, then pack the fields into a word.
  function automatic logic [8:0] fpack(input logic s, input logic signed [7:0] e,
                                       input logic [2:0] m);
    if (e <= 8'sd0)
      fpack = 9'h000;
    else if (e >= 8'sd31)
      fpack = {s, 5'd31, 3'd7};
    else
      fpack = {s, e[4:0], m};
  endfunction

  // Float multiply: 4x4-bit significand product, truncated to 3 mantissa bits.
  function automatic logic [8:0] fmul(input logic [8:0] a, input logic [8:0] b);
    logic [7:0]        p;
    logic signed [7:0] e;
    logic [2:0]        m;
    p = {4'b0000, 1'b1, a[2:0]} * {4'b0000, 1'b1, b[2:0]};
    e = $signed({3'b000, a[7:3]}) + $signed({3'b000, b[7:3]}) - 8'sd16;
    if (p[7]) begin
      m = p[6:4];
      e = e + 8'sd1;
    end else begin
      m = p[5:3];
    end
    if (a[7:3] == 5'd0 || b[7:3] == 5'd0)
      fmul = 9'h000;
    else
      fmul = fpack(a[8] ^ b[8], e, m);
  endfunction

  // Order the two operands by magnitude, then shift the smaller one right to the larger exponent.
  function automatic aln_t falign(input logic [8:0] x, input logic [8:0] y);
    logic [8:0] a;
    logic [8:0] b;
    logic [7:0] kx;
    logic [7:0] ky;
    logic [7:0] ka;
    logic [7:0] kb;
    logic [4:0] d;
    aln_t       r;
    kx = (x[7:3] == 5'd0) ? 8'h00 : x[7:0];
    ky = (y[7:3] == 5'd0) ? 8'h00 : y[7:0];
    if (ky > kx) begin
      a = y; b = x; ka = ky; kb = kx;
    end else begin
      a = x; b = y; ka = kx; kb = ky;
    end
    d       = ka[7:3] - kb[7:3];
    r       = '0;
    r.sign  = a[8];
    r.exp   = ka[7:3];
    r.sub   = a[8] ^ b[8];
    r.sig_a = (ka == 8'h00) ? 7'd0 : {1'b1, a[2:0], 3'b000};
    r.sig_b = (kb == 8'h00 || d > 5'd6) ? 7'd0 : ({1'b1, b[2:0], 3'b000} >> d);
    falign  = r;
  endfunction

  // Signed add, normalise left or right, and truncate. Exact cancellation gives +0.
  function automatic logic [8:0] fadd_norm(input aln_t s);
    logic [7:0]        sum;
    logic [7:0]        norm;
    logic [2:0]        lz;
    logic              found;
    logic signed [7:0] e;
    sum   = s.sub ? ({1'b0, s.sig_a} - {1'b0, s.sig_b}) : ({1'b0, s.sig_a} + {1'b0, s.sig_b});
    e     = $signed({3'b000, s.exp});
    lz    = 3'd0;
    found = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!found && sum[i]) begin
        found = 1'b1;
        lz    = 3'(6 - i);
      end
    end
    norm = sum << lz;
    if (sum == 8'd0)
      fadd_norm = 9'h000;
    else if (sum[7])
      fadd_norm = fpack(s.sign, e + 8'sd1, sum[6:4]);
    else
      fadd_norm = fpack(s.sign, e - $signed({5'b00000, lz}), norm[5:3]);
  endfunction

  logic          v1, v2, v3;
  logic [CW-1:0] cnt;

  // Valid shift chain and per-frame beat counter. START flushes both.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      cnt <= '0;
    end else if (START) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      cnt <= '0;
    end else begin
      v1 <= DIN_VALID;
      v2 <= v1;
      v3 <= v2;
      if (v3)
        cnt <= (cnt == CW'(BEATS - 1)) ? '0 : cnt + 1'b1;
    end
  end

  assign DOUT_VALID = v3;
  assign FRAME_DONE = v3 && (cnt == CW'(BEATS - 1));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [8:0] dr, di, wr, wi;
      logic [8:0] p_rr, p_ii, p_ri, p_ir;
      aln_t       aln_re, aln_im;
      logic [8:0] re_q, im_q;

      assign dr = DIN_RE[NB*gi +: NB];
      assign di = DIN_IM[NB*gi +: NB];
      assign wr = W_RE[NB*gi +: NB];
      assign wi = W_IM[NB*gi +: NB];

      // S1: compute the four real products of this lane's complex multiply.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          p_rr <= 9'h000;
          p_ii <= 9'h000;
          p_ri <= 9'h000;
          p_ir <= 9'h000;
        end else if (DIN_VALID && !START) begin
          p_rr <= fmul(dr, wr);
          p_ii <= fmul(di, wi);
          p_ri <= fmul(dr, wi);
          p_ir <= fmul(di, wr);
        end
      end

      // S2: align each pair. The real part subtracts di*wi, so that product's sign is flipped.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          aln_re <= '0;
          aln_im <= '0;
        end else if (v1 && !START) begin
          aln_re <= falign(p_rr, p_ii ^ 9'h100);
          aln_im <= falign(p_ri, p_ir);
        end
      end

`ifdef FFT_CMUL_TRIVIAL_BYPASS_EN
      logic       byp1, byp2;
      logic [8:0] d1_re, d1_im, d2_re, d2_im;

      // Carry the raw data and a twiddle-is-1+0j flag alongside S1 and S2.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          byp1  <= 1'b0;
          byp2  <= 1'b0;
          d1_re <= 9'h000;
          d1_im <= 9'h000;
          d2_re <= 9'h000;
          d2_im <= 9'h000;
        end else begin
          if (DIN_VALID && !START) begin
            byp1  <= (wr == 9'h080) && (wi == 9'h000);
            d1_re <= dr;
            d1_im <= di;
          end
          if (v1 && !START) begin
            byp2  <= byp1;
            d2_re <= d1_re;
            d2_im <= d1_im;
          end
        end
      end

      // S3: output the delayed data for a unit twiddle, otherwise the normalised sum.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          re_q <= 9'h000;
          im_q <= 9'h000;
        end else if (v2 && !START) begin
          re_q <= byp2 ? d2_re : fadd_norm(aln_re);
          im_q <= byp2 ? d2_im : fadd_norm(aln_im);
        end
      end
`else
      // S3: add, normalise, and register the lane result. The output holds while idle.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          re_q <= 9'h000;
          im_q <= 9'h000;
        end else if (v2 && !START) begin
          re_q <= fadd_norm(aln_re);
          im_q <= fadd_norm(aln_im);
        end
      end
`endif

      assign DOUT_RE[NB*gi +: NB] = re_q;
      assign DOUT_IM[NB*gi +: NB] = im_q;
    end
  endgenerate

endmodule
